fifo_rd_packer: RTL
===================

Name: fifo_rd_packer

Overview:
- Read-domain consumer placed directly downstream of async_fifo_top.
- Drains bytes from the FIFO read port and packs PACK consecutive bytes into one wide word.
- Presents each word on a valid/ready output with a one-entry holding register.
- A partial word left idle for TIMEOUT cycles is flushed with its byte count, so trailing data never strands.

Parameters:
- DATA_WIDTH, 8, width of one FIFO entry.
- PACK, 4, FIFO entries per output word (>=2).
- TIMEOUT, 16, idle cycles before a partial word is flushed (>=1).

Ports:
- rclk  input  1  read-domain clock; same clock as the FIFO read side.
- rrst  input  1  synchronous active-high reset.
- fifo_empty  input  1  FIFO empty flag (rclk domain).
- fifo_dout  input  DATA_WIDTH  FIFO read data; valid one cycle after an accepted rd_en.
- fifo_rd_en  output  1  FIFO pop request.
- out_valid  output  1  output word valid.
- out_ready  input  1  downstream accept.
- out_data  output  DATA_WIDTH*PACK  packed word; byte 0 (first popped) in the LSBs.
- out_bytes  output  $clog2(PACK)+1  number of valid bytes in out_data (1..PACK).

Behaviour:
- Only one clock and one reset are decided: rclk, with rrst synchronous and active-high. All state updates on posedge rclk.
- Reset:
  - fifo_rd_en=0, out_valid=0, out_data=0, out_bytes=0.
  - acc_cnt=0, rd_pend=0, idle_cnt=0, state=EMPTY.
  - Reset mid-word discards the partial accumulator and any in-flight byte; the in-flight byte is lost.
- Pop rule (combinational):
  - fifo_rd_en = !rrst && !fifo_empty && (acc_cnt + rd_pend < PACK).
  - rd_pend is registered as fifo_rd_en, so the cycle after a pop, fifo_dout is captured into lane acc_cnt and acc_cnt increments.
- Slot free = !out_valid || out_ready.
- States:
  - EMPTY (acc_cnt==0):
    - on byte arrival -> FILL, or -> FULL if PACK==1 is ever allowed (not allowed).
  - FILL (0<acc_cnt<PACK):
    - arrival making acc_cnt==PACK -> FULL.
    - idle_cnt reaching TIMEOUT with slot free -> flush: load out_data with lanes >= acc_cnt zeroed, out_bytes=acc_cnt, out_valid=1, acc_cnt=0, next state EMPTY.
  - FULL (acc_cnt==PACK):
    - no pops issued.
    - when slot free: load out_data, out_bytes=PACK, out_valid=1, acc_cnt=0, next state EMPTY.
    - otherwise hold.
- idle_cnt:
  - 0 in EMPTY/FULL, or on any cycle with rd_pend=1 or fifo_rd_en=1.
  - Otherwise increments in FILL, saturating at TIMEOUT.
  - A pop issued in the flush cycle is legal; its byte lands in lane 0 of the fresh accumulator.
- Output register:
  - out_valid clears on out_valid && out_ready unless reloaded the same cycle.
  - out_data and out_bytes are stable while out_valid && !out_ready.
  - Back-to-back load and drain in one cycle is supported.
- Latency: first pop to out_valid for a full word is PACK+2 cycles (pops in cycles 0..PACK-1, capture, transfer). Steady-state throughput is PACK bytes per PACK+2 cycles.
- Stall and ordering:
  - Never pop while acc_cnt+rd_pend==PACK; no byte is dropped under any out_ready pattern.
  - Byte order out equals FIFO order.
  - fifo_empty dropping while rd_pend is set does not cancel the pending capture.

Test Plan:
- Reset: hold rrst 3 cycles with fifo_empty=0 -> fifo_rd_en=0, out_valid=0, out_data=0 throughout; first pop on the first cycle after release.
- Full word: FIFO holds 01,02,03,04, out_ready=1 -> one word out_data=0x04030201, out_bytes=4, out_valid high exactly 1 cycle, 4 pops total.
- Backpressure: FIFO holds 01..0C, out_ready=0 for 20 cycles then 1 -> first word 0x04030201 held stable; accumulator stops at 4 bytes; exactly 8 pops before release; then words 0x08070605 and 0x0C0B0A09 in order with no loss.
- Timeout flush: push only 0A,0B, then fifo_empty=1 -> after TIMEOUT=16 idle cycles, out_data=0x00000B0A, out_bytes=2; a later byte 0C starts a new word in lane 0.
- Flush collision: fifo_empty deasserts in the flush cycle with byte 0D -> partial word emitted unchanged; 0D appears in lane 0 of the next word.
- Reset mid-word: after 3 bytes captured and 1 in flight, pulse rrst 1 cycle -> no output; next 4 FIFO bytes form a clean word with out_bytes=4.

Source files
------------

// File: rtl/fifo_rd_packer.sv
// fifo_rd_packer: drains an async FIFO read port and packs PACK entries
// into one wide word, flushing partial words after an idle timeout.
module fifo_rd_packer #(
  parameter int DATA_WIDTH = 8,
  parameter int PACK       = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic                       rclk,
  input  logic                       rrst,
  input  logic                       fifo_empty,
  input  logic [DATA_WIDTH-1:0]      fifo_dout,
  output logic                       fifo_rd_en,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_WIDTH*PACK-1:0] out_data,
  output logic [$clog2(PACK):0]      out_bytes
);

  localparam int CW = $clog2(PACK) + 1;
  localparam int IW = $clog2(PACK);
  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [CW:0]   PACK_S = (CW + 1)'(PACK);
  localparam logic [CW-1:0] LAST_C = CW'(PACK - 1);
  localparam logic [TW-1:0] TMO    = TW'(TIMEOUT);

  typedef enum logic [1:0] {
    EMPTY,
    FILL,
    FULL
  } state_t;

  state_t state, state_n;

  logic [CW-1:0]         acc_cnt, acc_cnt_n;
  logic                  rd_pend;
  logic [TW-1:0]         idle_cnt, idle_n;
  logic [DATA_WIDTH-1:0] lane [PACK];
  logic [CW:0]           inflight;
  logic                  slot_free;
  logic                  load;

  logic [DATA_WIDTH*PACK-1:0] word;

  // Bytes already captured plus the one still in flight bound the pops.
  assign inflight   = {1'b0, acc_cnt} + {{CW{1'b0}}, rd_pend};
  assign fifo_rd_en = !rrst && !fifo_empty && (inflight < PACK_S);
  assign slot_free  = !out_valid || out_ready;

  always_comb begin
    word = '0;
    for (int i = 0; i < PACK; i++) begin
      if (CW'(i) < acc_cnt) begin
        word[i*DATA_WIDTH +: DATA_WIDTH] = lane[i];
      end
    end
  end

  always_comb begin
    state_n   = state;
    acc_cnt_n = acc_cnt;
    load      = 1'b0;
    if (rd_pend) begin
      acc_cnt_n = acc_cnt + CW'(1);
    end
    unique case (state)
      EMPTY: begin
        if (rd_pend) begin
          state_n = FILL;
        end
      end
      FILL: begin
        if (rd_pend && acc_cnt == LAST_C) begin
          state_n = FULL;
        end else if (!rd_pend && idle_cnt == TMO && slot_free) begin
          load      = 1'b1;
          acc_cnt_n = '0;
          state_n   = EMPTY;
        end
      end
      FULL: begin
        if (slot_free) begin
          load      = 1'b1;
          acc_cnt_n = '0;
          state_n   = EMPTY;
        end
      end
      default: begin
        state_n = EMPTY;
      end
    endcase
  end

  always_comb begin
    idle_n = idle_cnt;
    if (state != FILL || rd_pend || fifo_rd_en) begin
      idle_n = '0;
    end else if (idle_cnt != TMO) begin
      idle_n = idle_cnt + TW'(1);
    end
  end

  always_ff @(posedge rclk) begin
    if (rrst) begin
      state     <= EMPTY;
      acc_cnt   <= '0;
      rd_pend   <= 1'b0;
      idle_cnt  <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_bytes <= '0;
    end else begin
      state    <= state_n;
      acc_cnt  <= acc_cnt_n;
      rd_pend  <= fifo_rd_en;
      idle_cnt <= idle_n;
      if (load) begin
        out_valid <= 1'b1;
        out_data  <= word;
        out_bytes <= acc_cnt;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  // Lanes past acc_cnt are masked on load, so they need no reset.
  always_ff @(posedge rclk) begin
    if (!rrst && rd_pend) begin
      lane[acc_cnt[IW-1:0]] <= fifo_dout;
    end
  end

endmodule
